// File: rtl/pool_relu_mc_if.sv
// Streaming sample/result bundle for pool_relu_mc.
// master drives samples, slave returns pooled results.
interface pool_relu_mc_if #(
    parameter int In_d_W = 32
);
    logic                     iInValid;
    logic signed [In_d_W-1:0] iPoolData;
    logic                     iMode;
    logic                     oOutValid;
    logic signed [In_d_W-1:0] oOutData;
    logic                     oFrameDone;

    modport master (
        output iInValid, iPoolData, iMode,
        input  oOutValid, oOutData, oFrameDone
    );

    modport slave (
        input  iInValid, iPoolData, iMode,
        output oOutValid, oOutData, oFrameDone
    );
endinterface

// File: rtl/pool_relu_mc.sv
// Multi-channel 2x2/stride-2 max|avg pooling + ReLU, one-cycle latency.
// Optional POOL_RELU_CLAMP_EN bounds results to CLAMP_MAX.
module pool_relu_mc #(
    parameter int In_d_W    = 32,
    parameter int W         = 26,
    parameter int H         = 26,
    parameter int CH        = 1,
    parameter int CLAMP_MAX = 6
) (
    input logic           iClk,
    input logic           iRsn,
    pool_relu_mc_if.slave bus
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam int XW = (W > 1) ? $clog2(W) : 1;
    localparam int YW = (H > 1) ? $clog2(H) : 1;
    localparam int LD = (W / 2) * CH;
    localparam int LW = (LD > 1) ? $clog2(LD) : 1;
    localparam int HW = In_d_W + 1;
    localparam int VW = In_d_W + 2;
    localparam bit W_ODD = (W % 2) == 1;

    logic [CW-1:0] ch_q, ch_d;
    logic [XW-1:0] col_q, col_d;
    logic [YW-1:0] row_q, row_d;
    logic          mode_q, mode_d;
    logic          out_valid_q, out_valid_d;
    logic          frame_done_q, frame_done_d;
    logic signed [In_d_W-1:0] out_data_q, out_data_d;

    // Storage is never read before it is written, so it carries no reset.
    logic signed [In_d_W-1:0] pair_mem [CH];
    logic signed [HW-1:0]     lb_mem [LD];

    logic accept, first, cur_mode;
    logic ch_last, col_last, row_last;
    logic pair_we, lb_we, win_done;
    logic [LW-1:0] lb_idx;
    logic signed [In_d_W-1:0] din, pa, relu, res;
    logic signed [HW-1:0] h_max, h_sum, h, lb_rd, v_max;
    logic signed [VW-1:0] v_sum, v_avg, v;

    always_comb begin
        accept   = bus.iInValid & iRsn;
        din      = bus.iPoolData;
        ch_last  = ch_q == CW'(CH - 1);
        col_last = col_q == XW'(W - 1);
        row_last = row_q == YW'(H - 1);
        first    = (ch_q == '0) && (col_q == '0) && (row_q == '0);
        cur_mode = first ? bus.iMode : mode_q;
        pair_we  = accept && !col_q[0] && !(W_ODD && col_last);
        lb_we    = accept && col_q[0] && !row_q[0];
        win_done = accept && col_q[0] && row_q[0];
        lb_idx   = LW'((int'(col_q) >> 1) * CH + int'(ch_q));
    end

    always_comb begin
        pa    = pair_mem[ch_q];
        lb_rd = lb_mem[lb_idx];
        h_sum = {pa[In_d_W-1], pa} + {din[In_d_W-1], din};
        h_max = (pa > din) ? {pa[In_d_W-1], pa}
                           : {din[In_d_W-1], din};
        h     = cur_mode ? h_sum : h_max;
        v_max = (lb_rd > h) ? lb_rd : h;
        v_sum = {lb_rd[HW-1], lb_rd} + {h[HW-1], h};
        // Arithmetic shift floors toward -inf for the average.
        v_avg = v_sum >>> 2;
        v     = cur_mode ? v_avg : {v_max[HW-1], v_max};
        relu  = (v < 0) ? '0 : v[In_d_W-1:0];
`ifdef POOL_RELU_CLAMP_EN
        res = (relu > In_d_W'(CLAMP_MAX)) ? In_d_W'(CLAMP_MAX) : relu;
`else
        res = relu;
`endif
    end

    always_comb begin
        ch_d         = ch_q;
        col_d        = col_q;
        row_d        = row_q;
        mode_d       = mode_q;
        out_valid_d  = win_done;
        out_data_d   = win_done ? res : out_data_q;
        frame_done_d = accept && ch_last && col_last && row_last;
        if (accept) begin
            ch_d = ch_last ? '0 : ch_q + CW'(1);
            if (first)
                mode_d = bus.iMode;
            if (ch_last) begin
                col_d = col_last ? '0 : col_q + XW'(1);
                if (col_last)
                    row_d = row_last ? '0 : row_q + YW'(1);
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRsn) begin
            ch_q         <= '0;
            col_q        <= '0;
            row_q        <= '0;
            mode_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            ch_q         <= ch_d;
            col_q        <= col_d;
            row_q        <= row_d;
            mode_q       <= mode_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge iClk) begin
        if (pair_we)
            pair_mem[ch_q] <= din;
        if (lb_we)
            lb_mem[lb_idx] <= h;
    end

    assign bus.oOutValid  = out_valid_q;
    assign bus.oOutData   = out_data_q;
    assign bus.oFrameDone = frame_done_q;
endmodule

// File: tb/tb_pool_relu_mc.sv
// Scoreboard bench for pool_relu_mc: three geometries, window-level model.
// Monitor pops expected results whenever a DUT presents oOutValid.
module tb_pool_relu_mc;
    typedef int iq_t[$];

    localparam int CLAMP = 6;
    int DW[3] = '{4, 4, 5};
    int DH[3] = '{2, 2, 3};
    int DC[3] = '{1, 2, 1};

    logic clk = 1'b0;
    logic rsn_a, rsn_b, rsn_c;
    always #5 clk = ~clk;

    pool_relu_mc_if #(.In_d_W(32)) ia ();
    pool_relu_mc_if #(.In_d_W(32)) ib ();
    pool_relu_mc_if #(.In_d_W(32)) ic ();

    pool_relu_mc #(.In_d_W(32), .W(4), .H(2), .CH(1), .CLAMP_MAX(CLAMP))
        dut_a (.iClk(clk), .iRsn(rsn_a), .bus(ia));
    pool_relu_mc #(.In_d_W(32), .W(4), .H(2), .CH(2), .CLAMP_MAX(CLAMP))
        dut_b (.iClk(clk), .iRsn(rsn_b), .bus(ib));
    pool_relu_mc #(.In_d_W(32), .W(5), .H(3), .CH(1), .CLAMP_MAX(CLAMP))
        dut_c (.iClk(clk), .iRsn(rsn_c), .bus(ic));

    int checks = 0;
    int failures = 0;
    int exp_a[$], exp_b[$], exp_c[$];
    int done_cnt[3] = '{0, 0, 0};
    int exp_done[3] = '{0, 0, 0};
    bit acc_prev[3] = '{0, 0, 0};

    // Reference: each 2x2 window evaluated directly from the raster frame.
    function automatic iq_t model(input int s[$], input int w, input int h,
                                  input int ch, input bit mode, input int n);
        iq_t r;
        longint a, b, c, d, t;
        for (int rr = 0; rr < h / 2; rr++)
            for (int cc = 0; cc < w / 2; cc++)
                for (int k = 0; k < ch; k++) begin
                    if (((2*rr+1)*w + 2*cc+1)*ch + k < n) begin
                        a = s[((2*rr)*w + 2*cc)*ch + k];
                        b = s[((2*rr)*w + 2*cc+1)*ch + k];
                        c = s[((2*rr+1)*w + 2*cc)*ch + k];
                        d = s[((2*rr+1)*w + 2*cc+1)*ch + k];
                        if (mode) begin
                            t = (a + b + c + d) >>> 2;
                        end else begin
                            t = a;
                            if (b > t) t = b;
                            if (c > t) t = c;
                            if (d > t) t = d;
                        end
                        if (t < 0) t = 0;
`ifdef POOL_RELU_CLAMP_EN
                        if (t > CLAMP) t = CLAMP;
`endif
                        r.push_back(int'(t));
                    end
                end
        return r;
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic mon(input int d, input int data, input bit accp);
        int e = 0;
        bit have = 0;
        case (d)
            0: if (exp_a.size() > 0) begin e = exp_a.pop_front(); have = 1; end
            1: if (exp_b.size() > 0) begin e = exp_b.pop_front(); have = 1; end
            default: if (exp_c.size() > 0) begin e = exp_c.pop_front(); have = 1; end
        endcase
        checks++;
        if (!have) begin
            failures++;
            $display("FAIL out_unexpected dut=%0d actual=%0d required=none", d, data);
        end else if (data != e || !accp) begin
            failures++;
            $display("FAIL out_data dut=%0d actual=%0d required=%0d accept_prev=%0d",
                     d, data, e, accp);
        end
    endtask

    always @(posedge clk) begin
        acc_prev[0] <= ia.iInValid && rsn_a;
        acc_prev[1] <= ib.iInValid && rsn_b;
        acc_prev[2] <= ic.iInValid && rsn_c;
    end

    always @(negedge clk) begin
        if (ia.oOutValid) mon(0, ia.oOutData, acc_prev[0]);
        if (ib.oOutValid) mon(1, ib.oOutData, acc_prev[1]);
        if (ic.oOutValid) mon(2, ic.oOutData, acc_prev[2]);
        if (ia.oFrameDone) begin
            done_cnt[0]++;
            chk("done_with_valid_a", ia.oOutValid, 1);
        end
        if (ib.oFrameDone) begin
            done_cnt[1]++;
            chk("done_with_valid_b", ib.oOutValid, 1);
        end
        if (ic.oFrameDone) done_cnt[2]++;
    end

    task automatic idle(input int g);
        repeat (g) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int d, input int v, input bit m);
        case (d)
            0: begin ia.iInValid = 1; ia.iPoolData = v; ia.iMode = m; end
            1: begin ib.iInValid = 1; ib.iPoolData = v; ib.iMode = m; end
            default: begin ic.iInValid = 1; ic.iPoolData = v; ic.iMode = m; end
        endcase
        @(posedge clk);
        #1;
        ia.iInValid = 0;
        ib.iInValid = 0;
        ic.iInValid = 0;
    endtask

    task automatic run(input int d, input bit mode, input int n, input bit tog,
                       input int maxgap, input int s[$]);
        iq_t e;
        bit m;
        e = model(s, DW[d], DH[d], DC[d], mode, n);
        foreach (e[i]) begin
            case (d)
                0: exp_a.push_back(e[i]);
                1: exp_b.push_back(e[i]);
                default: exp_c.push_back(e[i]);
            endcase
        end
        if (n == DW[d] * DH[d] * DC[d]) exp_done[d]++;
        for (int i = 0; i < n; i++) begin
            m = (tog && i > 0) ? 1'($urandom_range(0, 1)) : mode;
            if (maxgap > 0) idle($urandom_range(0, maxgap));
            send(d, s[i], m);
        end
    endtask

    function automatic iq_t rnd_frame(input int d);
        iq_t s;
        for (int i = 0; i < DW[d] * DH[d] * DC[d]; i++)
            s.push_back($urandom_range(0, 1) ? int'($urandom)
                                             : int'($urandom_range(0, 40)) - 20);
        return s;
    endfunction

    task automatic drain(input int d);
        int left;
        idle(3);
        left = (d == 0) ? exp_a.size() : (d == 1) ? exp_b.size() : exp_c.size();
        chk($sformatf("pending_dut%0d", d), left, 0);
        chk($sformatf("frame_done_cnt_dut%0d", d), done_cnt[d], exp_done[d]);
    endtask

    initial begin
        iq_t s;
        {ia.iInValid, ib.iInValid, ic.iInValid} = '0;
        {ia.iMode, ib.iMode, ic.iMode} = '0;
        ia.iPoolData = 0;
        ib.iPoolData = 0;
        ic.iPoolData = 0;
        rsn_a = 0;
        rsn_b = 0;
        rsn_c = 0;
        idle(2);
        chk("reset_a", {ia.oOutValid, ia.oFrameDone, ia.oOutData}, 0);
        chk("reset_b", {ib.oOutValid, ib.oFrameDone, ib.oOutData}, 0);
        chk("reset_c", {ic.oOutValid, ic.oFrameDone, ic.oOutData}, 0);
        rsn_a = 1;
        rsn_b = 1;
        rsn_c = 1;

        s = '{8, 4, -8, -4, 2, 2, -2, -2};
        run(0, 0, 8, 0, 0, s);
        run(0, 1, 8, 0, 0, s);
        drain(0);
        s = '{1, 0, 3, 3, 0, 0, 3, 3};
        run(0, 1, 8, 0, 0, s);
        s = '{9, 1, 5, 0, 1, 1, 0, 0};
        run(0, 0, 8, 0, 0, s);
        drain(0);
        for (int f = 0; f < 6; f++) begin
            s = rnd_frame(0);
            run(0, f[0], 8, 1, f % 3, s);
        end
        drain(0);

        s = '{1, -1, 2, -2, 3, -3, 4, -4, 5, -5, 6, -6, 7, -7, 8, -8};
        run(1, 0, 16, 0, 0, s);
        drain(1);
        for (int f = 0; f < 5; f++) begin
            s = rnd_frame(1);
            run(1, 1'($urandom_range(0, 1)), 16, 1, 1, s);
        end
        drain(1);

        for (int f = 0; f < 5; f++) begin
            s = rnd_frame(2);
            run(2, 1'($urandom_range(0, 1)), 15, 0, 3, s);
            drain(2);
        end
        s = rnd_frame(2);
        run(2, 1, 6, 0, 1, s);
        rsn_c = 0;
        idle(1);
        rsn_c = 1;
        s = rnd_frame(2);
        run(2, 0, 15, 1, 2, s);
        drain(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
